prime_event_counter: RTL

Parametrised, multi-lane successor to the single-lane prime counter. Each cycle it takes NUM_CH unsigned DATA_W-bit samples under a Valid qualifier. It classifies each lane as prime or not and accumulates the number of primes into a CNT_W-bit counter, either saturating or wrapping. It sits beside the datapath as a statistics/monitor block, with a sticky overflow flag and synchronous clear.

---
 rtl/prime_counter_pkg.sv | 37 +++
 rtl/prime_event_counter_lane.sv | 18 +
 rtl/prime_event_counter.sv | 85 ++++++++
 3 files changed

// File: rtl/prime_counter_pkg.sv
// Shared types and elaboration-time helpers for the prime event counter.
package prime_counter_pkg;

    // Accumulator behaviour once the running total passes the counter's range.
    typedef enum logic {
        CNT_SAT  = 1'b0,
        CNT_WRAP = 1'b1
    } count_mode_t;

    // Largest table ever needed: DATA_W is at most 8.
    localparam int MAX_TABLE_BITS = 256;

    // Trial division up to sqrt(v); only ever evaluated while elaborating.
    function automatic bit is_prime(input int v);
        bit p;
        p = (v >= 2);
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) begin
                p = 1'b0;
            end
        end
        return p;
    endfunction

    // Bit v of the result is 1 when v is prime; entries at or above 2**width stay 0.
    function automatic logic [MAX_TABLE_BITS-1:0] prime_table(input int width);
        logic [MAX_TABLE_BITS-1:0] t;
        t = '0;
        for (int v = 0; v < MAX_TABLE_BITS; v++) begin
            if (v < (1 << width)) begin
                t[v] = is_prime(v);
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/prime_event_counter_lane.sv
// One lane of primality classification: a constant lookup table, no arithmetic.
module prime_lane_detect
    import prime_counter_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] value,
    input  logic              valid,
    output logic              hit
);

    localparam int                        TABLE_BITS = 1 << DATA_W;
    localparam logic [MAX_TABLE_BITS-1:0] FULL_TABLE = prime_table(DATA_W);
    localparam logic [TABLE_BITS-1:0]     TABLE      = FULL_TABLE[TABLE_BITS-1:0];

    assign hit = valid & TABLE[value];

endmodule

// File: rtl/prime_event_counter.sv
// Multi-lane prime statistics counter: stage 1 registers per-lane prime flags,
// stage 2 adds their popcount into a saturating or wrapping counter with a
// sticky overflow flag.
//
// Handshake: Valid qualifies every lane of B in the cycle it is high. There is
// no ready; the block accepts a new set of lanes on every clock edge.
module prime_event_counter
    import prime_counter_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    parameter int NUM_CH = 1
) (
    input  logic                     Clk,
    input  logic                     nRst,
    input  logic                     Clear,
    input  logic                     Valid,
    input  count_mode_t              Mode,
    input  logic [NUM_CH*DATA_W-1:0] B,
    output logic [NUM_CH-1:0]        Hit,
    output logic [CNT_W-1:0]         N,
    output logic                     Ovf
);

    localparam int             INC_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W:0] MAX   = {1'b0, {CNT_W{1'b1}}};

    logic [NUM_CH-1:0] hit_d;
    logic [INC_W-1:0]  inc;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  n_next;
    logic              ovf_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        prime_lane_detect #(
            .DATA_W(DATA_W)
        ) u_lane (
            .value(B[i*DATA_W +: DATA_W]),
            .valid(Valid),
            .hit  (hit_d[i])
        );
    end

    // Count how many registered lanes were prime last cycle.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc = inc + INC_W'(Hit[i]);
        end
    end

    // One extra bit so the carry out of the counter is visible.
    assign sum = {1'b0, N} + (CNT_W+1)'(inc);

    // Saturate or wrap the running total; overflow only ever gets set here.
    always_comb begin
        n_next   = N;
        ovf_next = Ovf;
        if (Mode == CNT_SAT) begin
            if (sum > MAX) begin
                n_next   = MAX[CNT_W-1:0];
                ovf_next = 1'b1;
            end else begin
                n_next = sum[CNT_W-1:0];
            end
        end else begin
            n_next   = sum[CNT_W-1:0];
            ovf_next = Ovf | sum[CNT_W];
        end
    end

    // Pipeline and counter state; Clear drops both the new sample and the Hit in flight.
    always_ff @(posedge Clk) begin
        if (!nRst || Clear) begin
            Hit <= '0;
            N   <= '0;
            Ovf <= 1'b0;
        end else begin
            Hit <= hit_d;
            N   <= n_next;
            Ovf <= ovf_next;
        end
    end

endmodule
